// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - multiplexed 4-digit 7-segment scanner with guard, lz suppression and blink
module display_scanner #(
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYC    = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit3,
    input  logic [3:0] digit2,
    input  logic [3:0] digit1,
    input  logic [3:0] digit0,
    input  logic       update,
    input  logic       lz_en,
    input  logic       blink_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       frame_done
);

    localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DW-1:0] DIV_LAST   = DW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0] GUARD_LIM  = DW'(GUARD_CYC);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    typedef enum logic {GUARD, DRIVE} slot_state_t;

    slot_state_t   state, state_next;
    logic [DW-1:0] div_cnt, div_next;
    logic [1:0]    idx;
    logic          slot_end, frame_end;
    logic [15:0]   shadow, pending_data;
    logic          pending;
    logic [BW-1:0] blink_cnt;
    logic          blink_on;
    logic [3:0]    blank_vec;
    logic [3:0]    cur_code;
    logic [3:0]    an_d;
    logic [6:0]    seg_d;

    function automatic logic [6:0] decode(input logic [3:0] code);
        case (code)
            4'h0:    decode = 7'h40;
            4'h1:    decode = 7'h79;
            4'h2:    decode = 7'h24;
            4'h3:    decode = 7'h30;
            4'h4:    decode = 7'h19;
            4'h5:    decode = 7'h12;
            4'h6:    decode = 7'h02;
            4'h7:    decode = 7'h78;
            4'h8:    decode = 7'h00;
            4'h9:    decode = 7'h10;
            4'hA:    decode = 7'h2F;
            4'hB:    decode = 7'h2B;
            4'hC:    decode = 7'h23;
            4'hD:    decode = 7'h21;
            4'hE:    decode = 7'h06;
            default: decode = 7'h7F;
        endcase
    endfunction

    // Slot timing: divider wrap ends a slot, idx-0 slot end ends the frame; the
    // next FSM state follows from where the divider lands next cycle.
    always_comb begin
        slot_end   = (div_cnt == DIV_LAST);
        div_next   = slot_end ? '0 : div_cnt + DW'(1);
        frame_end  = slot_end && (idx == 2'd0);
        state_next = (div_next < GUARD_LIM) ? GUARD : DRIVE;
    end

    // Divider, slot index and slot FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= 2'd3;
            state   <= GUARD;
        end else begin
            div_cnt <= div_next;
            state   <= state_next;
            if (slot_end)
                idx <= idx - 2'd1;
        end
    end

    // Double-buffered digits: pending collects updates, shadow only changes at frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow       <= 16'hFFFF;
            pending_data <= 16'hFFFF;
            pending      <= 1'b0;
        end else if (frame_end) begin
            if (update)
                shadow <= {digit3, digit2, digit1, digit0};
            else if (pending)
                shadow <= pending_data;
            pending <= 1'b0;
        end else if (update) begin
            pending_data <= {digit3, digit2, digit1, digit0};
            pending      <= 1'b1;
        end
    end

    // Blink phase: counts whole frames and flips phase each time the count wraps.
    always_ff @(posedge clk) begin
        if (rst || !blink_en) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame_end) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    // Next anode/segment pattern from the current slot, shadow digit and blanking rules.
    always_comb begin
        blank_vec[3] = lz_en && (shadow[15:12] == 4'h0);
        blank_vec[2] = blank_vec[3] && (shadow[11:8] == 4'h0);
        blank_vec[1] = blank_vec[2] && (shadow[7:4] == 4'h0);
        blank_vec[0] = 1'b0;
        cur_code     = shadow[idx*4 +: 4];
        an_d         = 4'hF;
        seg_d        = 7'h7F;
        if (state == DRIVE && blink_on) begin
            an_d  = ~(4'b0001 << idx);
            seg_d = blank_vec[idx] ? 7'h7F : decode(cur_code);
        end
    end

    // Registered outputs, one cycle behind the counter/FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            an         <= 4'hF;
            seg        <= 7'h7F;
            frame_done <= 1'b0;
        end else begin
            an         <= an_d;
            seg        <= seg_d;
            frame_done <= frame_end;
        end
    end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clk cycles per digit slot, guard included; legal minimum GUARD_CYC+2.
REQ-002 SHALL have parameter GUARD_CYC, default 16, all-anodes-off cycles at the start of each slot.
REQ-003 SHALL have parameter BLINK_FRAMES, default 64, scan frames per blink half-period.
REQ-004 SHALL have ports, in this order: clk  in  1  the single clock; rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports digit3..digit0  in  4 each  glyph codes, digit3 leftmost.
REQ-006 SHALL have port update  in  1  strobe requesting capture of digit3..digit0.
REQ-007 SHALL have ports lz_en  in  1  leading-zero suppression; blink_en  in  1  blink the whole display.
REQ-008 SHALL have ports an  out  4  active-low anodes (an[3]=digit3); seg  out  7  active-low {g,f,e,d,c,b,a}; frame_done  out  1  frame-end pulse.

Function
REQ-009 SHALL decode codes to seg: 0-9 -> 40,79,24,30,19,12,02,78,00,10 hex; A 'r'->2F; B 'n'->2B; C 'o'->23; D 'd'->21; E 'E'->06; F blank->7F.
REQ-010 SHALL count div_cnt 0..REFRESH_DIV-1, wrapping to 0; each wrap ends a slot.
REQ-011 SHALL scan slot index 3,2,1,0, then wrap to 3; a frame ends at the end of the idx-0 slot.
REQ-012 SHALL run a two-state slot FSM, GUARD while div_cnt<GUARD_CYC and DRIVE otherwise; GUARD drives an=1111, seg=7F.
REQ-013 SHALL, in DRIVE, pull only an[idx] low and drive seg with the decoded shadow digit for idx.
REQ-014 SHALL register an and seg; the outputs in cycle t+1 reflect the counter/FSM state of cycle t (latency 1).
REQ-015 SHALL capture digit3..digit0 into a pending register on update and set a pending flag; a later update before the frame end overwrites it (last wins).
REQ-016 SHALL copy pending into the shadow register and clear the flag only at frame end; the display never changes mid-frame.
REQ-017 SHALL, when update coincides with the frame-end cycle, load that cycle's inputs directly into shadow and leave pending clear.
REQ-018 SHALL, with lz_en=1, render as blank: digit3 if its code is 0; digit2 if digit3 and digit2 are both 0; digit1 if digit3..digit1 are all 0; digit0 never.
REQ-019 SHALL evaluate the lz_en rule on shadow contents; a blanked digit keeps its anode asserted with seg=7F.
REQ-020 SHALL pulse frame_done for exactly one cycle, registered, in the cycle after the frame-end cycle.
REQ-021 SHALL, with blink_en=1, count frames 0..BLINK_FRAMES-1 and toggle blink phase on each wrap; in the off phase an=1111 and seg=7F for the whole frame.
REQ-022 SHALL, while blink_en=0, hold the blink count at 0 and force the phase on; on assertion, blinking starts at the on phase.
REQ-023 SHALL size counters as $clog2 of the parameter and never let a counter exceed parameter-1.

Reset
REQ-024 SHALL, on rst high at a clk edge, set div_cnt=0, idx=3, FSM=GUARD, shadow=FFFF (blank), pending clear, blink count 0, phase on.
REQ-025 SHALL, on the same edge, drive an=1111, seg=7F, frame_done=0.
REQ-026 SHALL give rst priority over update and the frame end; rst mid-slot discards pending, and scanning restarts at idx 3.

Verification (REFRESH_DIV=8, GUARD_CYC=2, BLINK_FRAMES=2)
REQ-027 SHALL cover: rst; update 1,2,3,4 -> after frame_done, the idx-3 slot shows an=1111 for 2 cycles, then an=0111, seg=79 for 6 cycles; then 2/24, 3/30, 4/19.
REQ-028 SHALL cover: update D,C,B,E -> seg 21,23,2B,06 on an 0111,1011,1101,1110.
REQ-029 SHALL cover: lz_en=1, update 0,0,5,0 -> seg 7F,7F,12,40; with lz_en=0 -> 40,40,12,40.
REQ-030 SHALL cover: update 1111 then update 2222 mid-frame -> the current frame is unchanged, the next frame shows all 24.
REQ-031 SHALL cover: blink_en=1 -> 2 frames of normal scan, then 2 frames of an=1111, repeating; frame_done still pulses every frame.
REQ-032 SHALL cover: rst asserted at div_cnt=5 in the idx-1 slot -> next cycle an=1111, seg=7F, shadow blank; after 2 guard cycles, idx 3 drives seg=7F.
